// File: rtl/mmio_bus_arbiter.sv
// Two-master arbiter for the MMIO peripheral register block.
// Every transaction runs IDLE -> ACCESS -> DONE, and the slave bus is driven only during ACCESS.
module mmio_bus_arbiter #(
    parameter int unsigned ARB_MODE  = 0,
    parameter int unsigned MAX_WAIT  = 4,
    parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        s_we,
    output logic [3:0]  s_be,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    output logic        gnt_id,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    state_t      r_state;
    logic        r_m0_ack;
    logic        r_m1_ack;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;
    logic        r_s_we;
    logic [3:0]  r_s_be;
    logic [31:0] r_s_addr;
    logic [31:0] r_s_wdata;
    logic        r_gnt_id;
    logic        r_busy;
    logic        r_last_grant;
    logic [3:0]  r_wait_cnt;

    logic        w_any_req;
    logic        w_pick_m1;
    logic        w_sel_we;
    logic [3:0]  w_sel_be;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;

    always_comb begin
        w_any_req = m0_req | m1_req;
        if (ARB_MODE == 0) begin
            w_pick_m1 = m1_req & (~m0_req | ~r_last_grant);
        end else begin
            w_pick_m1 = m1_req & (~m0_req | (r_wait_cnt == LP_MAX_WAIT));
        end
        w_sel_we    = w_pick_m1 ? m1_we    : m0_we;
        w_sel_be    = w_pick_m1 ? m1_be    : m0_be;
        w_sel_addr  = w_pick_m1 ? m1_addr  : m0_addr;
        w_sel_wdata = w_pick_m1 ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
            r_s_we       <= 1'b0;
            r_s_be       <= '0;
            r_s_addr     <= IDLE_ADDR;
            r_s_wdata    <= '0;
            r_gnt_id     <= 1'b0;
            r_busy       <= 1'b0;
            r_last_grant <= 1'b1;
            r_wait_cnt   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    // Starvation counter only moves when m1 actually asks and loses.
                    if (!m1_req || w_pick_m1) begin
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt != LP_MAX_WAIT) begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                    if (w_any_req) begin
                        r_s_we       <= w_sel_we;
                        r_s_be       <= w_sel_be;
                        r_s_addr     <= w_sel_addr;
                        r_s_wdata    <= w_sel_wdata;
                        r_gnt_id     <= w_pick_m1;
                        r_last_grant <= w_pick_m1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!r_s_we) begin
                        if (r_gnt_id) begin
                            r_m1_rdata <= s_rdata;
                        end else begin
                            r_m0_rdata <= s_rdata;
                        end
                    end
                    r_m0_ack  <= ~r_gnt_id;
                    r_m1_ack  <= r_gnt_id;
                    r_s_we    <= 1'b0;
                    r_s_be    <= '0;
                    r_s_addr  <= IDLE_ADDR;
                    r_s_wdata <= '0;
                    r_state   <= ST_DONE;
                end
                ST_DONE: begin
                    r_m0_ack <= 1'b0;
                    r_m1_ack <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0_ack   = r_m0_ack;
    assign m1_ack   = r_m1_ack;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;
    assign s_we     = r_s_we;
    assign s_be     = r_s_be;
    assign s_addr   = r_s_addr;
    assign s_wdata  = r_s_wdata;
    assign gnt_id   = r_gnt_id;
    assign busy     = r_busy;

endmodule
